// File: rtl/parking_slot_controller.sv
// Parking lot occupancy sequencer: arbitrates entry/exit gate requests, picks the
// lowest free slot for arrivals and owns the occupancy bitmap (updated by XOR mask).
module parking_slot_controller #(
  parameter int N_SLOTS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic [2:0]         exit_slot,
  output logic               entry_ack,
  output logic               entry_reject,
  output logic [2:0]         entry_slot,
  output logic               exit_ack,
  output logic               exit_err,
  output logic [N_SLOTS-1:0] park_location,
  output logic [N_SLOTS-1:0] parking_capacity,
  output logic [3:0]         free_count,
  output logic               full,
  output logic               empty
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK, RELEASE} state_t;

  state_t     state, state_d;
  logic       op_exit, op_ok, last_exit;
  logic [2:0] op_slot;
  logic       grant, grant_exit, exit_hit;
  logic [2:0] free_idx;

  // Occupancy decode; the descending scan leaves the lowest-index free slot in free_idx.
  always_comb begin
    free_count = 4'(N_SLOTS);
    free_idx   = 3'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      free_count = free_count - {3'b000, parking_capacity[i]};
      if (!parking_capacity[i]) free_idx = 3'(i);
    end
  end

  assign full     = &parking_capacity;
  assign empty    = ~|parking_capacity;
  assign exit_hit = (int'(exit_slot) < N_SLOTS) && parking_capacity[exit_slot];

  always_comb begin
    state_d       = state;
    grant         = 1'b0;
    grant_exit    = 1'b0;
    park_location = '0;
    entry_ack     = 1'b0;
    entry_reject  = 1'b0;
    exit_ack      = 1'b0;
    exit_err      = 1'b0;
    entry_slot    = 3'd0;
    case (state)
      IDLE: begin
        if (entry_req || exit_req) begin
          grant      = 1'b1;
          // On a tie, serve whichever side was not granted last.
          grant_exit = exit_req && (!entry_req || !last_exit);
          state_d    = SERVE;
        end
      end
      SERVE: begin
        if (op_ok) park_location = {{(N_SLOTS-1){1'b0}}, 1'b1} << op_slot;
        state_d = ACK;
      end
      ACK: begin
        entry_ack    = !op_exit &&  op_ok;
        entry_reject = !op_exit && !op_ok;
        exit_ack     =  op_exit &&  op_ok;
        exit_err     =  op_exit && !op_ok;
        if (entry_ack) entry_slot = op_slot;
        state_d      = RELEASE;
      end
      RELEASE: begin
        if (!(op_exit ? exit_req : entry_req)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      parking_capacity <= '0;
      op_exit          <= 1'b0;
      op_ok            <= 1'b0;
      op_slot          <= 3'd0;
      last_exit        <= 1'b0;
    end else begin
      state            <= state_d;
      parking_capacity <= parking_capacity ^ park_location;
      if (grant) begin
        // Slot and outcome are fixed at grant time and never re-evaluated.
        op_exit <= grant_exit;
        op_slot <= grant_exit ? exit_slot : free_idx;
        op_ok   <= grant_exit ? exit_hit  : !full;
      end
      if (state == ACK) last_exit <= op_exit;
    end
  end

endmodule

// File: tb/tb_parking_slot_controller.sv
// Directed bench for parking_slot_controller: hand-computed vectors checked with
// immediate assertions, inputs driven and outputs sampled on the falling edge.
module tb_parking_slot_controller;
  logic       clk = 1'b0;
  logic       rst_n, entry_req, exit_req;
  logic [2:0] exit_slot;
  logic       entry_ack, entry_reject, exit_ack, exit_err, full, empty;
  logic [2:0] entry_slot;
  logic [7:0] park_location, parking_capacity;
  logic [3:0] free_count;
  int         nvec = 0;
  int         nerr = 0;

  parking_slot_controller #(.N_SLOTS(8)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .entry_ack(entry_ack), .entry_reject(entry_reject),
    .entry_slot(entry_slot), .exit_ack(exit_ack), .exit_err(exit_err),
    .park_location(park_location), .parking_capacity(parking_capacity),
    .free_count(free_count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request(s) must already be high. kind: 0 entry_ack, 1 entry_reject, 2 exit_ack, 3 exit_err.
  // Drops the served request after the ACK cycle and returns on a falling edge in IDLE.
  task automatic expect_op(input string tag, input logic [7:0] mask, input int kind,
                           input logic [2:0] eslot, input logic [7:0] bitmap);
    logic [3:0] pulses;
    pulses = 4'b1000 >> kind;
    @(posedge clk); @(negedge clk);
    chk({tag, ".mask"}, park_location, mask);
    chk({tag, ".pulse_serve"}, {entry_ack, entry_reject, exit_ack, exit_err}, 4'b0000);
    @(posedge clk); @(negedge clk);
    chk({tag, ".pulses"}, {entry_ack, entry_reject, exit_ack, exit_err}, pulses);
    chk({tag, ".entry_slot"}, entry_slot, eslot);
    chk({tag, ".bitmap"}, parking_capacity, bitmap);
    chk({tag, ".mask_ack"}, park_location, 8'h00);
    if (kind < 2) entry_req = 1'b0; else exit_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, ".pulse_rel"}, {entry_ack, entry_reject, exit_ack, exit_err}, 4'b0000);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 3'd0;
    @(negedge clk); @(negedge clk);
    chk("rst.bitmap", parking_capacity, 8'h00);
    chk("rst.free", free_count, 4'd8);
    chk("rst.flags", {empty, full}, 2'b10);
    chk("rst.outs", {entry_ack, entry_reject, exit_ack, exit_err, entry_slot, park_location}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three arrivals take slots 0,1,2
    entry_req = 1'b1; expect_op("ent0", 8'h01, 0, 3'd0, 8'h01);
    entry_req = 1'b1; expect_op("ent1", 8'h02, 0, 3'd1, 8'h03);
    entry_req = 1'b1; expect_op("ent2", 8'h04, 0, 3'd2, 8'h07);
    chk("fill3.free", free_count, 4'd5);

    // Free slot 1, then the next arrival reuses it
    exit_slot = 3'd1; exit_req = 1'b1; expect_op("ex1", 8'h02, 2, 3'd0, 8'h05);
    entry_req = 1'b1; expect_op("ent_reuse", 8'h02, 0, 3'd1, 8'h07);

    // Fill the lot, then an arrival is rejected
    entry_req = 1'b1; expect_op("ent3", 8'h08, 0, 3'd3, 8'h0F);
    entry_req = 1'b1; expect_op("ent4", 8'h10, 0, 3'd4, 8'h1F);
    entry_req = 1'b1; expect_op("ent5", 8'h20, 0, 3'd5, 8'h3F);
    entry_req = 1'b1; expect_op("ent6", 8'h40, 0, 3'd6, 8'h7F);
    entry_req = 1'b1; expect_op("ent7", 8'h80, 0, 3'd7, 8'hFF);
    chk("full.flags", {empty, full, free_count}, {2'b01, 4'd0});
    entry_req = 1'b1; expect_op("ent_full", 8'h00, 1, 3'd0, 8'hFF);
    chk("full.after", full, 1'b1);

    // Exit from an empty lot is an error and leaves the bitmap alone
    do_reset();
    exit_slot = 3'd4; exit_req = 1'b1; expect_op("ex_free", 8'h00, 3, 3'd0, 8'h00);
    chk("ex_free.empty", empty, 1'b1);

    // Reset during SERVE with bitmap 0F; held entry is then served fresh
    entry_req = 1'b1; expect_op("r0", 8'h01, 0, 3'd0, 8'h01);
    entry_req = 1'b1; expect_op("r1", 8'h02, 0, 3'd1, 8'h03);
    entry_req = 1'b1; expect_op("r2", 8'h04, 0, 3'd2, 8'h07);
    entry_req = 1'b1; expect_op("r3", 8'h08, 0, 3'd3, 8'h0F);
    entry_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst.serve_mask", park_location, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("midrst.bitmap", parking_capacity, 8'h00);
    chk("midrst.mask", park_location, 8'h00);
    chk("midrst.outs", {entry_ack, entry_reject, exit_ack, exit_err, entry_slot}, 0);
    chk("midrst.status", {free_count, empty, full}, {4'd8, 2'b10});
    @(negedge clk);
    rst_n = 1'b1;
    expect_op("midrst.new", 8'h01, 0, 3'd0, 8'h01);

    // Tie arbitration: first tie after reset goes to exit
    do_reset();
    exit_slot = 3'd0; entry_req = 1'b1; exit_req = 1'b1;
    expect_op("tie1.exit", 8'h00, 3, 3'd0, 8'h00);
    expect_op("tie1.entry", 8'h01, 0, 3'd0, 8'h01);
    entry_req = 1'b1; exit_req = 1'b1;
    expect_op("tie2.exit", 8'h01, 2, 3'd0, 8'h00);
    expect_op("tie2.entry", 8'h01, 0, 3'd0, 8'h01);
    // After a lone exit, the next tie goes to entry
    exit_req = 1'b1; expect_op("lone.exit", 8'h01, 2, 3'd0, 8'h00);
    entry_req = 1'b1; exit_req = 1'b1;
    expect_op("tie3.entry", 8'h01, 0, 3'd0, 8'h01);
    expect_op("tie3.exit", 8'h01, 2, 3'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
